// File: rtl/operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : operand_feeder
//  Purpose  : Accepts one k-slice (a column of A, a row of B) per handshake
//             and skews each lane through a delay line one register deeper
//             than its index, so a systolic array sees the wavefront it
//             expects. A FLUSH phase then waits for all products to land in
//             the PEs before done_o is pulsed.
//  Revision : 1.0 - initial release
// ============================================================================
module operand_feeder #(
   parameter int SYS_ARRAY_SIZE = 4,
   parameter int DATA_W         = 8,
   parameter int K_MAX          = 64,
   parameter int KW             = $clog2(K_MAX + 1)
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic                                    in_valid_i,
   output logic                                    in_ready_o,
   input  logic                                    in_last_i,
   input  logic [SYS_ARRAY_SIZE-1:0][DATA_W-1:0]   a_col_i,
   input  logic [SYS_ARRAY_SIZE-1:0][DATA_W-1:0]   b_row_i,
   output logic [SYS_ARRAY_SIZE-1:0][DATA_W-1:0]   a_o,
   output logic [SYS_ARRAY_SIZE-1:0][DATA_W-1:0]   b_o,
   output logic                                    busy_o,
   output logic                                    done_o,
   output logic [KW-1:0]                           k_count_o
);

   // Flush length: the last beat needs N cycles to clear the deepest lane,
   // then 2N-2 more to ripple across the array to the far corner PE.
   localparam int             FW           = $clog2(3 * SYS_ARRAY_SIZE - 1);
   localparam logic [FW-1:0]  c_FLUSH_LOAD = FW'(3 * SYS_ARRAY_SIZE - 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FEED  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   logic            r_ready;
   logic            r_busy;
   logic            r_done;
   logic [KW-1:0]   r_k;
   logic [FW-1:0]   r_flush;

   logic            w_accept;
   logic [KW-1:0]   w_k_next;
   logic            w_last;

   // A transfer happens only while ready; the count restarts on a job's first beat
   // and a beat that fills the K_MAX budget closes the job on its own.
   assign w_accept = in_valid_i & r_ready;
   assign w_k_next = (r_state == S_IDLE) ? KW'(1) : (r_k + KW'(1));
   assign w_last   = in_last_i | (w_k_next == KW'(K_MAX));

   // Job sequencing FSM with registered handshake/status outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_k     <= '0;
         r_flush <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_FEED: begin
               if (w_accept) begin
                  r_k    <= w_k_next;
                  r_busy <= 1'b1;
                  if (w_last) begin
                     r_state <= S_FLUSH;
                     r_flush <= c_FLUSH_LOAD;
                     r_ready <= 1'b0;
                  end else begin
                     r_state <= S_FEED;
                  end
               end
            end
            S_FLUSH: begin
               r_flush <= r_flush - FW'(1);
               if (r_flush == FW'(1)) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o = r_ready;
   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign k_count_o  = r_k;

   for (genvar gi = 0; gi < SYS_ARRAY_SIZE; gi++) begin : g_lane
      logic [DATA_W-1:0] r_a_dly [0:gi];
      logic [DATA_W-1:0] r_b_dly [0:gi];
      logic [DATA_W-1:0] w_a_in;
      logic [DATA_W-1:0] w_b_in;

      // Non-transfer cycles push zero bubbles so stalls keep A and B aligned.
      assign w_a_in = w_accept ? a_col_i[gi] : '0;
      assign w_b_in = w_accept ? b_row_i[gi] : '0;

      // Lane delay line: shifts in every state so flushing beats still emerge.
      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i) begin
            for (int s = 0; s <= gi; s++) begin
               r_a_dly[s] <= '0;
               r_b_dly[s] <= '0;
            end
         end else begin
            r_a_dly[0] <= w_a_in;
            r_b_dly[0] <= w_b_in;
            for (int s = 1; s <= gi; s++) begin
               r_a_dly[s] <= r_a_dly[s-1];
               r_b_dly[s] <= r_b_dly[s-1];
            end
         end
      end

      assign a_o[gi] = r_a_dly[gi];
      assign b_o[gi] = r_b_dly[gi];
   end

endmodule
`default_nettype wire

// File: tb/tb_operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_feeder
//  Purpose  : Self-checking bench for operand_feeder (N=4, DATA_W=8,
//             K_MAX=4). Expected outputs come from a cycle-indexed history
//             of accepted beats and job arithmetic on cycle numbers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_feeder;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int KM  = 4;
   localparam int KW  = $clog2(KM + 1);
   localparam int HN  = 4096;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic                 in_valid_i;
   logic                 in_ready_o;
   logic                 in_last_i;
   logic [N-1:0][DW-1:0] a_col_i;
   logic [N-1:0][DW-1:0] b_row_i;
   logic [N-1:0][DW-1:0] a_o;
   logic [N-1:0][DW-1:0] b_o;
   logic                 busy_o;
   logic                 done_o;
   logic [KW-1:0]        k_count_o;

   operand_feeder #(
      .SYS_ARRAY_SIZE (N),
      .DATA_W         (DW),
      .K_MAX          (KM)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_last_i  (in_last_i),
      .a_col_i    (a_col_i),
      .b_row_i    (b_row_i),
      .a_o        (a_o),
      .b_o        (b_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .k_count_o  (k_count_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: which cycles transferred a beat, and the beat data.
   bit                   hv [0:HN-1];
   logic [N-1:0][DW-1:0] ha [0:HN-1];
   logic [N-1:0][DW-1:0] hb [0:HN-1];
   int                   m_k;
   bit                   m_feeding;
   int                   m_done_cyc;

   task automatic model_reset();
      for (int i = 0; i < HN; i++) hv[i] = 1'b0;
      m_k        = 0;
      m_feeding  = 1'b0;
      m_done_cyc = -100;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // One clock cycle: drive, check at the falling edge, then update the model.
   task automatic step_d(input bit v, input bit l,
                         input logic [N-1:0][DW-1:0] a,
                         input logic [N-1:0][DW-1:0] b);
      logic [N-1:0][DW-1:0] ea;
      logic [N-1:0][DW-1:0] eb;
      bit                   acc;
      int                   nk;
      in_valid_i = v;
      in_last_i  = l;
      a_col_i    = a;
      b_row_i    = b;
      @(negedge clk_i);
      for (int i = 0; i < N; i++) begin
         int idx = cyc - i - 1;
         ea[i] = (idx >= 0 && hv[idx]) ? ha[idx][i] : '0;
         eb[i] = (idx >= 0 && hv[idx]) ? hb[idx][i] : '0;
      end
      chk("a_o",   64'(a_o), 64'(ea));
      chk("b_o",   64'(b_o), 64'(eb));
      chk("ready", 64'(in_ready_o), 64'(cyc > m_done_cyc));
      chk("busy",  64'(busy_o), 64'(m_feeding || cyc <= m_done_cyc));
      chk("done",  64'(done_o), 64'(cyc == m_done_cyc));
      chk("k",     64'(k_count_o), 64'(m_k));
      acc     = v && (cyc > m_done_cyc);
      hv[cyc] = acc;
      ha[cyc] = a;
      hb[cyc] = b;
      if (acc) begin
         nk = m_feeding ? m_k + 1 : 1;
         m_k = nk;
         if (l || nk == KM) begin
            m_feeding  = 1'b0;
            m_done_cyc = cyc + 3 * N - 1;
         end else begin
            m_feeding = 1'b1;
         end
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic step(input bit v, input bit l);
      logic [N-1:0][DW-1:0] a;
      logic [N-1:0][DW-1:0] b;
      for (int i = 0; i < N; i++) begin
         a[i] = DW'($urandom);
         b[i] = DW'($urandom);
      end
      step_d(v, l, a, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   // Asserts reset mid-cycle, checks the asynchronous clear, releases next cycle.
   task automatic pulse_reset();
      rst_i      = 1'b0;
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      #2;
      chk("rst_a_o",   64'(a_o), 64'd0);
      chk("rst_b_o",   64'(b_o), 64'd0);
      chk("rst_ready", 64'(in_ready_o), 64'd1);
      chk("rst_busy",  64'(busy_o), 64'd0);
      chk("rst_done",  64'(done_o), 64'd0);
      chk("rst_k",     64'(k_count_o), 64'd0);
      @(posedge clk_i);
      #1;
      cyc++;
      rst_i = 1'b1;
      model_reset();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0][DW-1:0] a34;
      logic [N-1:0][DW-1:0] b34;
      a34 = {8'd4, 8'd3, 8'd2, 8'd1};
      b34 = {8'd8, 8'd7, 8'd6, 8'd5};
      rst_i      = 1'b1;
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      a_col_i    = '0;
      b_row_i    = '0;
      model_reset();
      #1;
      pulse_reset();

      // Single-beat job with known data.
      step_d(1'b1, 1'b1, a34, b34);
      idle(12);

      // Three back-to-back beats, last on the third.
      step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b1);
      idle(12);

      // Two beats separated by a two-cycle stall.
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b1);
      idle(12);

      // Six beats offered without last: the K_MAX-th one closes the job.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      idle(10);

      // Reset in the middle of FLUSH aborts the job; then a clean job.
      step(1'b1, 1'b0); step(1'b1, 1'b1);
      idle(4);
      pulse_reset();
      step_d(1'b1, 1'b1, a34, b34);
      idle(12);

      // Second job waiting with valid held high through the first job's flush.
      step(1'b1, 1'b0); step(1'b1, 1'b1);
      for (int i = 0; i < 13; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      idle(12);

      // Randomized valid/last traffic.
      for (int i = 0; i < 60; i++) step(($urandom % 4) != 0, ($urandom % 3) == 0);
      idle(14);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
